// File: rtl/l2_loop_ctrl_if.sv
// l2_loop_ctrl_if: TX/RX FIFO read ports plus the AHB-side TX read view.
// The master side is the loop controller; the slave side is the environment.
interface l2_loop_ctrl_if #(
    parameter int DW = 32
);
    logic          tx_fifo_empty;
    logic [DW-1:0] tx_fifo_dout;
    logic          tx_fifo_rd_en;
    logic          rx_fifo_empty;
    logic [DW-1:0] rx_fifo_dout;
    logic          rx_fifo_rd_en_dbg;
    logic          tx_fifo_empty_ahb;
    logic [DW-1:0] tx_fifo_dout_ahb;
    logic          tx_fifo_rd_en_ahb;

    modport master (
        input  tx_fifo_empty, tx_fifo_dout,
        output tx_fifo_rd_en,
        input  rx_fifo_empty, rx_fifo_dout,
        output rx_fifo_rd_en_dbg,
        output tx_fifo_empty_ahb, tx_fifo_dout_ahb,
        input  tx_fifo_rd_en_ahb
    );

    modport slave (
        output tx_fifo_empty, tx_fifo_dout,
        input  tx_fifo_rd_en,
        output rx_fifo_empty, rx_fifo_dout,
        input  rx_fifo_rd_en_dbg,
        input  tx_fifo_empty_ahb, tx_fifo_dout_ahb,
        output tx_fifo_rd_en_ahb
    );
endinterface

// File: rtl/l2_loop_ctrl.sv
// l2_loop_ctrl: steers the AHB TX read view onto the RX FIFO in loop mode.
// Optional loop word counter is built only when L2_LOOP_CNT_EN is defined.
module l2_loop_ctrl #(
    parameter int DW        = 32,
    parameter int CNT_W     = 16,
    parameter int GUARD_CYC = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             pin_l2_loop,
    l2_loop_ctrl_if.master   bus,
    output logic             loop_active,
    output logic             loop_busy,
    input  logic             loop_cnt_clr,
    output logic [CNT_W-1:0] loop_cnt
);
    typedef enum logic [1:0] {NORM, GUARD, LOOP} state_e;

    localparam logic [7:0] GCNT_INIT = 8'(GUARD_CYC);

    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic          tgt_q, tgt_d;
    logic [7:0]    gcnt_q, gcnt_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          pin_s;
    logic          tx_rd, rx_rd;
    logic          empty_ahb;
    logic [DW-1:0] dout_ahb;

    assign sync_d = {sync_q[0], pin_l2_loop};
    assign pin_s  = sync_q[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= NORM;
            sync_q  <= '0;
            tgt_q   <= 1'b0;
            gcnt_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            tgt_q   <= tgt_d;
            gcnt_q  <= gcnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            NORM: begin
                if (pin_s) begin
                    state_d = GUARD;
                    tgt_d   = 1'b1;
                    gcnt_d  = GCNT_INIT;
                end
            end
            LOOP: begin
                if (!pin_s) begin
                    state_d = GUARD;
                    tgt_d   = 1'b0;
                    gcnt_d  = GCNT_INIT;
                end
            end
            GUARD: begin
                // A pin that changes mid-guard restarts the full guard.
                if (pin_s != tgt_q) begin
                    tgt_d  = pin_s;
                    gcnt_d = GCNT_INIT;
                end else if (gcnt_q <= 8'd1) begin
                    state_d = tgt_q ? LOOP : NORM;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
            default: state_d = NORM;
        endcase
    end

    always_comb begin
        empty_ahb = bus.tx_fifo_empty;
        dout_ahb  = bus.tx_fifo_dout;
        tx_rd     = 1'b0;
        rx_rd     = 1'b0;
        hold_d    = hold_q;
        unique case (state_q)
            NORM: begin
                tx_rd  = bus.tx_fifo_rd_en_ahb & ~bus.tx_fifo_empty;
                hold_d = bus.tx_fifo_dout;
            end
            LOOP: begin
                empty_ahb = bus.rx_fifo_empty;
                dout_ahb  = bus.rx_fifo_dout;
                rx_rd     = bus.tx_fifo_rd_en_ahb & ~bus.rx_fifo_empty;
                hold_d    = bus.rx_fifo_dout;
            end
            GUARD: begin
                empty_ahb = 1'b1;
                dout_ahb  = hold_q;
            end
            default: ;
        endcase
    end

    // Reset gates the enables so nothing is popped while held in reset.
    assign bus.tx_fifo_rd_en     = tx_rd & HRESETn;
    assign bus.rx_fifo_rd_en_dbg = rx_rd & HRESETn;
    assign bus.tx_fifo_empty_ahb = empty_ahb;
    assign bus.tx_fifo_dout_ahb  = dout_ahb;

    assign loop_active = (state_q == LOOP);
    assign loop_busy   = (state_q == GUARD);

`ifdef L2_LOOP_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (loop_cnt_clr) begin
            cnt_d = '0;
        end else if (rx_rd && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign loop_cnt = cnt_q;
`else
    logic unused_clr;

    assign unused_clr = loop_cnt_clr;
    assign loop_cnt   = '0;
`endif

endmodule
